// File: rtl/traffic_light_controller_n.sv
// N-road traffic light controller: round-robin green arbitration from car sensors,
// cycle-count phase timers and a parade mode that pins green on one road.
module traffic_light_controller_n #(
    parameter int unsigned N_ROADS     = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned MIN_GREEN   = 4,
    parameter int unsigned MAX_GREEN   = 12,
    parameter int unsigned YELLOW_TIME = 2,
    parameter int unsigned ALLRED_TIME = 1,
    parameter int unsigned PARADE_ROAD = 0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [N_ROADS-1:0]           i_sensor,
    input  logic                         i_P,
    input  logic                         i_R,
    output logic [2*N_ROADS-1:0]         o_light,
    output logic [$clog2(N_ROADS)-1:0]   o_active,
    output logic                         o_parade
);

    localparam int unsigned AW = $clog2(N_ROADS);
    localparam int unsigned LW = 2 * N_ROADS;

    localparam logic [CNT_W-1:0] T_MIN_GREEN = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] T_MAX_GREEN = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] T_YELLOW    = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] T_ALLRED    = CNT_W'(ALLRED_TIME - 1);
    localparam logic [CNT_W-1:0] T_SAT       = {CNT_W{1'b1}};
    localparam logic [AW-1:0]    PARADE_IDX  = AW'(PARADE_ROAD);

    localparam logic [1:0] LAMP_GREEN  = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_RED    = 2'b10;

    typedef enum logic [1:0] {
        ST_GREEN  = 2'b00,
        ST_YELLOW = 2'b01,
        ST_ALLRED = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    cur_q, cur_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             parade_q, parade_d;
    logic [LW-1:0]    light_q, light_d;

    logic [N_ROADS-1:0] req_c;
    logic [AW-1:0]      nxt_c;
    logic               leave_green_c;

    // Lamp pattern for a given phase and owning road; every other road is red.
    function automatic logic [LW-1:0] lamp_decode(input state_e st, input logic [AW-1:0] road);
        logic [LW-1:0] lamps;
        lamps = '0;
        for (int k = 0; k < int'(N_ROADS); k++) begin
            lamps[2*k +: 2] = LAMP_RED;
            if (AW'(k) == road) begin
                if (st == ST_GREEN) begin
                    lamps[2*k +: 2] = LAMP_GREEN;
                end else if (st == ST_YELLOW) begin
                    lamps[2*k +: 2] = LAMP_YELLOW;
                end
            end
        end
        return lamps;
    endfunction

    // Competing demand and the next requester after cur in wrap-around order.
    // Scanning from the far end down lets the nearest requester win.
    always_comb begin
        req_c        = i_sensor;
        req_c[cur_q] = 1'b0;
        nxt_c        = cur_q;
        for (int k = int'(N_ROADS) - 1; k >= 1; k--) begin
            if (req_c[AW'((32'(cur_q) + 32'(k)) % N_ROADS)]) begin
                nxt_c = AW'((32'(cur_q) + 32'(k)) % N_ROADS);
            end
        end
    end

    // Green release: minimum green served, then vacated, max-green, or parade redirect.
    always_comb begin
        leave_green_c = 1'b0;
        if (timer_q >= T_MIN_GREEN) begin
            if (parade_q) begin
                leave_green_c = (cur_q != PARADE_IDX);
            end else begin
                leave_green_c = (|req_c) && (!i_sensor[cur_q] || (timer_q >= T_MAX_GREEN));
            end
        end
    end

    // Phase sequencing, timer, parade flag and registered lamp decode.
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        parade_d = parade_q;
        timer_d  = timer_q;

        case (state_q)
            ST_GREEN: begin
                if (leave_green_c) begin
                    state_d = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                if (timer_q == T_YELLOW) begin
                    state_d = ST_ALLRED;
                end
            end
            ST_ALLRED: begin
                if (timer_q == T_ALLRED) begin
                    state_d = ST_GREEN;
                    cur_d   = parade_q ? PARADE_IDX : nxt_c;
                end
            end
            default: begin
                state_d = ST_GREEN;
            end
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q != T_SAT) begin
            timer_d = timer_q + CNT_W'(1);
        end

        if (i_P && !i_R) begin
            parade_d = 1'b1;
        end else if (i_R && !i_P) begin
            parade_d = 1'b0;
        end

        light_d = lamp_decode(state_d, cur_d);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_GREEN;
            cur_q    <= '0;
            timer_q  <= '0;
            parade_q <= 1'b0;
            light_q  <= lamp_decode(ST_GREEN, '0);
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            timer_q  <= timer_d;
            parade_q <= parade_d;
            light_q  <= light_d;
        end
    end

    assign o_light  = light_q;
    assign o_active = cur_q;
    assign o_parade = parade_q;

endmodule

// File: tb/tb_traffic_light_controller_n.sv
// Self-checking bench for traffic_light_controller_n at default parameters:
// behavioural reference model feeding a scoreboard, plus directed scenario checks.
module tb_traffic_light_controller_n;

    localparam int N     = 4;
    localparam int MING  = 4;
    localparam int MAXG  = 12;
    localparam int YEL   = 2;
    localparam int ARED  = 1;
    localparam int PROAD = 0;
    localparam int TSAT  = 255;

    localparam logic [7:0] L_R0_G = 8'hA8;
    localparam logic [7:0] L_R0_Y = 8'hA9;
    localparam logic [7:0] L_R1_G = 8'hA2;
    localparam logic [7:0] L_R1_Y = 8'hA6;
    localparam logic [7:0] L_R2_G = 8'h8A;
    localparam logic [7:0] L_ALLR = 8'hAA;

    logic       clk;
    logic       rst;
    logic [3:0] sensor;
    logic       p_req;
    logic       r_req;
    logic [7:0] o_light;
    logic [1:0] o_active;
    logic       o_parade;

    typedef struct packed {
        logic [7:0] light;
        logic [1:0] act;
        logic       par;
    } exp_t;

    exp_t sb[$];

    int n_chk = 0;
    int n_bad = 0;

    // model state: 0 green, 1 yellow, 2 all-red
    int m_st  = 0;
    int m_cur = 0;
    int m_tmr = 0;
    bit m_par = 1'b0;

    traffic_light_controller_n #(
        .N_ROADS    (N),
        .CNT_W      (8),
        .MIN_GREEN  (MING),
        .MAX_GREEN  (MAXG),
        .YELLOW_TIME(YEL),
        .ALLRED_TIME(ARED),
        .PARADE_ROAD(PROAD)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_sensor(sensor),
        .i_P     (p_req),
        .i_R     (r_req),
        .o_light (o_light),
        .o_active(o_active),
        .o_parade(o_parade)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_light();
        logic [7:0] lt;
        lt = L_ALLR;
        if (m_st == 0) lt[2*m_cur +: 2] = 2'b00;
        else if (m_st == 1) lt[2*m_cur +: 2] = 2'b01;
        return lt;
    endfunction

    // One rising edge of the reference behaviour, using the inputs currently driven.
    task automatic model_edge();
        int  nst;
        int  ncur;
        int  nx;
        bit  found;
        bit  leave;
        logic [3:0] req;
        if (rst) begin
            m_st = 0; m_cur = 0; m_tmr = 0; m_par = 1'b0;
            return;
        end
        req = sensor;
        req[m_cur] = 1'b0;
        nx = m_cur;
        found = 1'b0;
        for (int k = 1; k < N; k++) begin
            if (!found && req[(m_cur + k) % N]) begin
                nx = (m_cur + k) % N;
                found = 1'b1;
            end
        end
        nst = m_st;
        ncur = m_cur;
        leave = 1'b0;
        if (m_st == 0) begin
            if (m_tmr >= MING - 1) begin
                if (m_par) leave = (m_cur != PROAD);
                else leave = (req != 0) && (!sensor[m_cur] || m_tmr >= MAXG - 1);
            end
            if (leave) nst = 1;
        end else if (m_st == 1) begin
            if (m_tmr == YEL - 1) nst = 2;
        end else begin
            if (m_tmr == ARED - 1) begin
                nst = 0;
                ncur = m_par ? PROAD : nx;
            end
        end
        if (nst != m_st) m_tmr = 0;
        else if (m_tmr < TSAT) m_tmr = m_tmr + 1;
        m_st = nst;
        m_cur = ncur;
        if (p_req && !r_req) m_par = 1'b1;
        else if (r_req && !p_req) m_par = 1'b0;
    endtask

    // Predict, push, clock, then pop and compare the DUT against the prediction.
    task automatic step();
        exp_t e;
        exp_t g;
        logic any11;
        model_edge();
        e.light = model_light();
        e.act   = 2'(m_cur);
        e.par   = m_par;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk("light", 32'(o_light), 32'(g.light));
        chk("active", 32'(o_active), 32'(g.act));
        chk("parade", 32'(o_parade), 32'(g.par));
        any11 = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (o_light[2*k +: 2] == 2'b11) any11 = 1'b1;
        end
        chk("lamp11", 32'(any11), 32'd0);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sensor = 4'b0000; p_req = 1'b0; r_req = 1'b0;
        @(negedge clk);

        // reset state
        do_reset();
        chk("rst_light", 32'(o_light), 32'(L_R0_G));
        chk("rst_active", 32'(o_active), 32'd0);
        chk("rst_parade", 32'(o_parade), 32'd0);

        // single requester on road 2
        sensor = 4'b0100;
        steps(3);
        chk("single_g_end", 32'(o_light), 32'(L_R0_G));
        step();
        chk("single_yel", 32'(o_light), 32'(L_R0_Y));
        steps(2);
        chk("single_allred", 32'(o_light), 32'(L_ALLR));
        step();
        chk("single_r2", 32'(o_light), 32'(L_R2_G));
        chk("single_act2", 32'(o_active), 32'd2);
        steps(20);
        chk("single_hold", 32'(o_light), 32'(L_R2_G));

        // max-green preemption between roads 0 and 1
        do_reset();
        sensor = 4'b0011;
        steps(11);
        chk("max_g_last", 32'(o_light), 32'(L_R0_G));
        step();
        chk("max_yel", 32'(o_light), 32'(L_R0_Y));
        steps(3);
        chk("max_r1", 32'(o_light), 32'(L_R1_G));
        steps(15);
        chk("max_r0_back", 32'(o_light), 32'(L_R0_G));
        chk("max_act0", 32'(o_active), 32'd0);

        // wrap-around from road 3 to road 0, roads 1/2 skipped
        do_reset();
        sensor = 4'b1000;
        steps(7);
        chk("wrap_act3", 32'(o_active), 32'd3);
        sensor = 4'b0001;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("wrap_r1_red", 32'(o_light[3:2]), 32'(2'b10));
            chk("wrap_r2_red", 32'(o_light[5:4]), 32'(2'b10));
        end
        chk("wrap_r0", 32'(o_light), 32'(L_R0_G));

        // parade start while road 2 is green, hold on road 0, then end
        do_reset();
        sensor = 4'b0100;
        steps(8);
        p_req = 1'b1;
        step();
        p_req = 1'b0;
        chk("par_set", 32'(o_parade), 32'd1);
        sensor = 4'b1110;
        steps(20);
        chk("par_hold", 32'(o_light), 32'(L_R0_G));
        p_req = 1'b1; r_req = 1'b1;
        step();
        chk("par_both", 32'(o_parade), 32'd1);
        p_req = 1'b0;
        step();
        r_req = 1'b0;
        chk("par_clear", 32'(o_parade), 32'd0);
        steps(4);
        chk("par_r1", 32'(o_light), 32'(L_R1_G));

        // no demand, then a request that withdraws before all-red ends
        do_reset();
        sensor = 4'b0000;
        steps(110);
        chk("idle_r0", 32'(o_light), 32'(L_R0_G));
        sensor = 4'b0010;
        step();
        chk("wd_yel", 32'(o_light), 32'(L_R0_Y));
        steps(2);
        chk("wd_allred", 32'(o_light), 32'(L_ALLR));
        sensor = 4'b0000;
        step();
        chk("wd_back_r0", 32'(o_light), 32'(L_R0_G));
        chk("wd_act0", 32'(o_active), 32'd0);

        // reset during road 1 yellow, parade request ignored under reset
        do_reset();
        sensor = 4'b0010;
        steps(7);
        sensor = 4'b0001;
        steps(4);
        chk("rsty_yel", 32'(o_light), 32'(L_R1_Y));
        p_req = 1'b1;
        do_reset();
        p_req = 1'b0;
        chk("rsty_light", 32'(o_light), 32'(L_R0_G));
        chk("rsty_act", 32'(o_active), 32'd0);
        chk("rsty_par", 32'(o_parade), 32'd0);
        sensor = 4'b0010;
        steps(3);
        chk("rsty_tmr0", 32'(o_light), 32'(L_R0_G));
        steps(10);

        // random traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            sensor = 4'($urandom_range(0, 15));
            p_req  = ($urandom_range(0, 19) == 0);
            r_req  = ($urandom_range(0, 19) == 0);
            rst    = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0; p_req = 1'b0; r_req = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
